// File: rtl/haar_pkg.sv
`default_nettype none
// ============================================================================
// Package   : haar_pkg
// Purpose   : Shared window geometry, entry width and the state type used by
//             the integral image builder and its row accumulator.
// Contents  : IMG_W, IMG_H, INT_W, NPIX, state_e
// Revision  : 1.0 - initial release
// ============================================================================
package haar_pkg;

   localparam int IMG_W = 20;             // pixels per window row
   localparam int IMG_H = 20;             // rows per window
   localparam int INT_W = 32;             // bits per integral entry
   localparam int NPIX  = IMG_W * IMG_H;  // entries in one window

   // Frame-level control states; explicit 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // waiting for a start-of-frame pixel
      ST_ACCUM = 2'd1,   // accumulating the frame in raster order
      ST_DONE  = 2'd2    // buffer complete and frozen until frame_ack
   } state_e;

endpackage : haar_pkg
`default_nettype wire

// File: rtl/integral_image_builder_if.sv
`default_nettype none
// ============================================================================
// Interface : integral_image_builder_if
// Purpose   : Pixel stream in, completed integral buffer out, plus the
//             frame hand-back from the downstream comparator.
// Signals   : pix_data[7:0], pix_valid, pix_sof  (source -> builder)
//             pix_ready                          (builder -> source)
//             frame_ack                          (comparator -> builder)
//             integral_buffer[NPIX][INT_W], START (builder -> comparator)
// Modports  : master - pixel source / comparator side
//             slave  - the integral image builder
// Revision  : 1.0 - initial release
// ============================================================================
interface integral_image_builder_if #(
   parameter int IMG_W = haar_pkg::IMG_W,
   parameter int IMG_H = haar_pkg::IMG_H,
   parameter int INT_W = haar_pkg::INT_W
);

   logic [7:0]                           pix_data;
   logic                                 pix_valid;
   logic                                 pix_sof;
   logic                                 pix_ready;
   logic                                 frame_ack;
   // Entry for pixel (x,y) lives at index y*IMG_W + x.
   logic [IMG_W*IMG_H-1:0][INT_W-1:0]    integral_buffer;
   logic                                 START;

   modport master (
      output pix_data,
      output pix_valid,
      output pix_sof,
      output frame_ack,
      input  pix_ready,
      input  integral_buffer,
      input  START
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      input  pix_sof,
      input  frame_ack,
      output pix_ready,
      output integral_buffer,
      output START
   );

endinterface : integral_image_builder_if
`default_nettype wire

// File: rtl/integral_row_accum.sv
`default_nettype none
// ============================================================================
// Module    : integral_row_accum
// Purpose   : Tracks the raster position (x,y) and the running sum of the
//             current row. Produces, for the pixel presented this cycle, its
//             buffer address and the row prefix sum including that pixel.
// Ports     : clk_i       - clock
//             rst_n_i     - asynchronous active-low reset
//             accept_i    - pixel is processed on this edge
//             restart_i   - treat the presented pixel as (0,0)
//             pix_i[7:0]  - presented pixel
//             addr_o      - y*IMG_W + x of the presented pixel
//             row_sum_o   - row prefix sum up to and including the pixel
//             first_row_o - presented pixel is in row 0
//             last_o      - presented pixel is (IMG_W-1, IMG_H-1)
// Revision  : 1.0 - initial release
// ============================================================================
module integral_row_accum #(
   parameter int IMG_W  = 20,
   parameter int IMG_H  = 20,
   parameter int INT_W  = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              accept_i,
   input  logic              restart_i,
   input  logic [7:0]        pix_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [INT_W-1:0]  row_sum_o,
   output logic              first_row_o,
   output logic              last_o
);

   localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

   logic [X_W-1:0]   x_q, x_d, x_cur;
   logic [Y_W-1:0]   y_q, y_d, y_cur;
   logic [INT_W-1:0] row_sum_q, row_sum_d;

   always_comb begin
      // A restarting pixel is always (0,0), whatever the counters say.
      x_cur       = restart_i ? '0 : x_q;
      y_cur       = restart_i ? '0 : y_q;
      row_sum_o   = ((x_cur == '0) ? '0 : row_sum_q) + INT_W'(pix_i);
      addr_o      = ADDR_W'(y_cur) * ADDR_W'(IMG_W) + ADDR_W'(x_cur);
      first_row_o = (y_cur == '0);
      last_o      = (x_cur == X_MAX) && (y_cur == Y_MAX);

      x_d       = x_q;
      y_d       = y_q;
      row_sum_d = row_sum_q;
      if (accept_i) begin
         row_sum_d = row_sum_o;
         if (x_cur == X_MAX) begin
            x_d = '0;
            // Wrap to (0,0) after the last pixel so the next frame starts clean.
            y_d = (y_cur == Y_MAX) ? '0 : y_cur + 1'b1;
         end else begin
            x_d = x_cur + 1'b1;
            y_d = y_cur;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         x_q       <= '0;
         y_q       <= '0;
         row_sum_q <= '0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         row_sum_q <= row_sum_d;
      end
   end

endmodule : integral_row_accum
`default_nettype wire

// File: rtl/integral_image_builder.sv
`default_nettype none
// ============================================================================
// Module    : integral_image_builder
// Purpose   : Builds the integral (summed-area) image of one IMG_W x IMG_H
//             window from a raster pixel stream and hands the completed
//             buffer to a downstream HAAR comparator.
// Ports     : Clk     - single clock, rising edge
//             Reset_n - asynchronous active-low reset
//             bus     - integral_image_builder_if.slave (pixel stream,
//                       pix_ready, frame_ack, integral_buffer, START)
// Revision  : 1.0 - initial release
// ============================================================================
module integral_image_builder #(
   parameter int IMG_W = haar_pkg::IMG_W,
   parameter int IMG_H = haar_pkg::IMG_H,
   parameter int INT_W = haar_pkg::INT_W
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   integral_image_builder_if.slave  bus
);

   import haar_pkg::*;

   localparam int N_ENTRY = IMG_W * IMG_H;
   localparam int ADDR_W  = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;

   state_e                          state_q, state_d;
   logic                            ready_q;
   logic [N_ENTRY-1:0][INT_W-1:0]   buf_q;

   logic                            xfer;
   logic                            accept;
   logic [ADDR_W-1:0]               wr_addr;
   logic [ADDR_W-1:0]               above_addr;
   logic [INT_W-1:0]                row_sum;
   logic [INT_W-1:0]                wr_data;
   logic                            first_row;
   logic                            last;

   // ready is registered so it reads 0 throughout reset and rises on the
   // first edge after release; it always mirrors "state is not DONE".
   assign xfer = bus.pix_valid & ready_q;

   // In IDLE only a start-of-frame pixel is processed; anything else is dropped.
   assign accept = xfer && ((state_q == ST_ACCUM) ||
                            ((state_q == ST_IDLE) && bus.pix_sof));

   integral_row_accum #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .INT_W  (INT_W),
      .ADDR_W (ADDR_W)
   ) u_row_accum (
      .clk_i       (Clk),
      .rst_n_i     (Reset_n),
      .accept_i    (accept),
      .restart_i   (bus.pix_sof),
      .pix_i       (bus.pix_data),
      .addr_o      (wr_addr),
      .row_sum_o   (row_sum),
      .first_row_o (first_row),
      .last_o      (last)
   );

   // Entry directly above has already been written in this frame because
   // rows arrive in order; row 0 has nothing above it.
   assign above_addr = first_row ? '0 : wr_addr - ADDR_W'(IMG_W);
   assign wr_data    = row_sum + (first_row ? '0 : buf_q[above_addr]);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = last ? ST_DONE : ST_ACCUM;
         end
         ST_ACCUM: begin
            if (accept && last) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.frame_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != ST_DONE);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         buf_q <= '0;
      end else if (accept) begin
         buf_q[wr_addr] <= wr_data;
      end
   end

   assign bus.pix_ready       = ready_q;
   assign bus.integral_buffer = buf_q;
   assign bus.START           = (state_q == ST_DONE);

endmodule : integral_image_builder
`default_nettype wire

// File: tb/tb_integral_image_builder.sv
`default_nettype none
// ============================================================================
// Module    : tb_integral_image_builder
// Purpose   : Self-checking bench for integral_image_builder. Frames are
//             compared against a direct rectangle-sum model of the integral
//             image computed from the stored frame pixels.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_integral_image_builder;

   localparam int W = 20;
   localparam int H = 20;
   localparam int N = W * H;

   logic Clk;
   logic Reset_n;

   integral_image_builder_if #(.IMG_W(W), .IMG_H(H), .INT_W(32)) bus ();

   integral_image_builder #(.IMG_W(W), .IMG_H(H), .INT_W(32)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  frm  [N];
   longint      expv [N];
   logic [31:0] snap [N];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Integral entry = sum of every pixel in the rectangle (0,0)..(x,y).
   task automatic build_model();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            longint s = 0;
            for (int j = 0; j <= y; j++)
               for (int i = 0; i <= x; i++)
                  s += longint'(frm[j*W + i]);
            expv[y*W + x] = s;
         end
   endtask

   task automatic check_buffer(input string tag);
      int bad = 0;
      for (int k = 0; k < N; k++)
         if (bus.integral_buffer[k] !== 32'(expv[k])) bad++;
      check(tag, 64'(bad), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      int bad = 0;
      for (int k = 0; k < N; k++)
         if (bus.integral_buffer[k] !== 32'd0) bad++;
      check(tag, 64'(bad), 64'd0);
   endtask

   task automatic push(input logic [7:0] p, input logic sof, input int max_gap);
      int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      int n = 0;
      repeat (g) begin
         bus.pix_valid = 1'b0;
         bus.pix_data  = 8'($urandom);
         bus.pix_sof   = 1'($urandom);
         @(posedge Clk); #1;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = p;
      bus.pix_sof   = sof;
      while (bus.pix_ready !== 1'b1 && n < 50) begin
         @(posedge Clk); #1;
         n++;
      end
      if (n >= 50) check("ready_timeout", 64'(bus.pix_ready), 64'd1);
      @(posedge Clk); #1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
   endtask

   task automatic send_frame(input string tag, input int max_gap);
      for (int k = 0; k < N; k++) begin
         push(frm[k], (k == 0), max_gap);
         if (k == N - 2) check({tag, "_start_early"}, 64'(bus.START), 64'd0);
      end
      check({tag, "_start"}, 64'(bus.START), 64'd1);
      check({tag, "_ready_done"}, 64'(bus.pix_ready), 64'd0);
      build_model();
      check_buffer({tag, "_buf"});
   endtask

   task automatic ack();
      bus.frame_ack = 1'b1;
      @(posedge Clk); #1;
      bus.frame_ack = 1'b0;
      check("ack_start", 64'(bus.START), 64'd0);
      check("ack_ready", 64'(bus.pix_ready), 64'd1);
   endtask

   initial begin
      int bad_rdy;
      int bad_start;
      int bad_buf;

      bus.pix_data  = 8'd0;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.frame_ack = 1'b0;
      Reset_n       = 1'b0;

      // Reset state
      #12;
      check("rst_ready", 64'(bus.pix_ready), 64'd0);
      check("rst_start", 64'(bus.START), 64'd0);
      check_zero("rst_buf");
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      @(posedge Clk); #1;
      check("rst_release_ready", 64'(bus.pix_ready), 64'd1);

      // All-ones frame, no gaps
      for (int k = 0; k < N; k++) frm[k] = 8'd1;
      send_frame("ones", 0);
      check("ones_e399", 64'(bus.integral_buffer[399]), 64'd400);
      check("ones_e47", 64'(bus.integral_buffer[2*W + 7]), 64'(8 * 3));
      ack();

      // Non-sof pixels in IDLE are dropped and the buffer is kept
      for (int k = 0; k < 5; k++) push(8'd99, 1'b0, 0);
      check("idle_drop_start", 64'(bus.START), 64'd0);
      check_buffer("idle_drop_buf");

      // frame_ack while IDLE does nothing
      bus.frame_ack = 1'b1;
      @(posedge Clk); #1;
      bus.frame_ack = 1'b0;
      check("idle_ack_ready", 64'(bus.pix_ready), 64'd1);
      check("idle_ack_start", 64'(bus.START), 64'd0);

      // All-255 frame with random gaps
      for (int k = 0; k < N; k++) frm[k] = 8'd255;
      send_frame("max_gap", 3);
      check("max_e399", 64'(bus.integral_buffer[399]), 64'd102000);
      check("max_e19", 64'(bus.integral_buffer[19]), 64'd5100);
      check("max_e380", 64'(bus.integral_buffer[380]), 64'd5100);

      // DONE holds: 50 cycles of offered pixels with no ack
      for (int k = 0; k < N; k++) snap[k] = bus.integral_buffer[k];
      bad_rdy = 0; bad_start = 0;
      for (int c = 0; c < 50; c++) begin
         bus.pix_valid = 1'b1;
         bus.pix_data  = 8'($urandom);
         bus.pix_sof   = 1'($urandom);
         @(posedge Clk); #1;
         if (bus.pix_ready !== 1'b0) bad_rdy++;
         if (bus.START !== 1'b1) bad_start++;
      end
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bad_buf = 0;
      for (int k = 0; k < N; k++)
         if (bus.integral_buffer[k] !== snap[k]) bad_buf++;
      check("done_hold_ready", 64'(bad_rdy), 64'd0);
      check("done_hold_start", 64'(bad_start), 64'd0);
      check("done_hold_buf", 64'(bad_buf), 64'd0);
      ack();

      // Ramp frame
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) frm[y*W + x] = 8'((x + y) & 8'hFF);
      send_frame("ramp", 2);
      ack();

      // Random frame
      for (int k = 0; k < N; k++) frm[k] = 8'($urandom);
      send_frame("rand", 2);
      ack();

      // Restart: 150 random pixels, a stray frame_ack, then a fresh ones frame
      for (int k = 0; k < 150; k++) push(8'($urandom), (k == 0), 1);
      bus.frame_ack = 1'b1;
      @(posedge Clk); #1;
      bus.frame_ack = 1'b0;
      check("partial_start", 64'(bus.START), 64'd0);
      for (int k = 0; k < N; k++) frm[k] = 8'd1;
      send_frame("restart", 1);
      check("restart_e399", 64'(bus.integral_buffer[399]), 64'd400);
      ack();

      // Asynchronous reset mid-frame at pixel 200
      for (int k = 0; k < 200; k++) push(8'($urandom), (k == 0), 1);
      #2;
      Reset_n = 1'b0;
      #1;
      check("arst_ready", 64'(bus.pix_ready), 64'd0);
      check("arst_start", 64'(bus.START), 64'd0);
      check_zero("arst_buf");
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      for (int k = 0; k < N; k++) frm[k] = 8'($urandom);
      send_frame("post_rst", 1);
      ack();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time bound so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_integral_image_builder
`default_nettype wire
